// File: rtl/reduce_sched.sv
// Round-robin scheduler sharing one modular reduction pipeline (mod 3329)
// among NREQ requesters, with the owner tag carried alongside each result.

module reduce (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] c,
   output logic [11:0] r
);
   // Barrett estimate q = floor(c * floor(2^24/3329) / 2^24) is exact or one low,
   // so c - q*3329 lies in [0, 6658) and 13-bit arithmetic is sufficient.
   localparam logic [36:0] BARRETT_M = 37'd5039;
   localparam logic [12:0] MODULUS   = 13'd3329;

   logic [12:0] q_next;
   logic [12:0] q_q;
   logic [12:0] c_lo_q;
   logic [12:0] rem_wide;
   logic [11:0] rem_final;
   logic [11:0] r_q;

   assign q_next = 13'(({13'b0, c} * BARRETT_M) >> 24);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q    <= '0;
         c_lo_q <= '0;
      end else begin
         q_q    <= q_next;
         c_lo_q <= c[12:0];
      end
   end

   assign rem_wide  = c_lo_q - 13'(q_q * MODULUS);
   assign rem_final = (rem_wide >= MODULUS) ? 12'(rem_wide - MODULUS) : rem_wide[11:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= '0;
      end else begin
         r_q <= rem_final;
      end
   end

   assign r = r_q;

endmodule

module reduce_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int LAT  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [24*NREQ-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   output logic               resp_valid,
   output logic [IDW-1:0]     resp_id,
   output logic [11:0]        resp_data,
   output logic               idle,
   output logic [15:0]        op_count
);
   // Handshake: requester i transfers in any cycle where req_valid[i] & req_ready[i];
   // req_ready is a one-hot combinational grant, and responses are never back-pressured.

   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  gnt_id;
   logic            found;
   logic [IDW:0]    idx;
   logic            xfer;
   logic [23:0]     operand;
   logic [LAT-1:0]  tag_v;
   logic [IDW-1:0]  tag_id [LAT];

   always_comb begin
      found  = 1'b0;
      gnt_id = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr} + (IDW+1)'(k);
         if (idx >= (IDW+1)'(NREQ)) begin
            idx = idx - (IDW+1)'(NREQ);
         end
         if (!found && req_valid[idx[IDW-1:0]]) begin
            found  = 1'b1;
            gnt_id = idx[IDW-1:0];
         end
      end
   end

   assign req_ready = found ? (NREQ'(1) << gnt_id) : '0;
   assign xfer      = found;
   assign operand   = found ? req_data[gnt_id*24 +: 24] : 24'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         op_count <= '0;
      end else if (xfer) begin
         ptr      <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
         op_count <= op_count + 16'd1;
      end
   end

   // Tag shift register matches the reduce latency so id and data line up.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
         for (int k = 0; k < LAT; k++) begin
            tag_id[k] <= '0;
         end
      end else begin
         tag_v     <= {tag_v[LAT-2:0], xfer};
         tag_id[0] <= gnt_id;
         for (int k = 1; k < LAT; k++) begin
            tag_id[k] <= tag_id[k-1];
         end
      end
   end

   reduce u_reduce (
      .clk (clk),
      .rst (rst),
      .c   (operand),
      .r   (resp_data)
   );

   assign resp_valid = tag_v[LAT-1];
   assign resp_id    = tag_id[LAT-1];
   assign idle       = ~|req_valid & ~|tag_v;

endmodule

// File: tb/tb_reduce_sched.sv
// Directed bench for reduce_sched: reset, single op, boundary operands,
// fairness, pointer skip, reset mid-flight and op_count wrap.

module tb_reduce_sched;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic               clk;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [24*NREQ-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               resp_valid;
   logic [IDW-1:0]     resp_id;
   logic [11:0]        resp_data;
   logic               idle;
   logic [15:0]        op_count;

   int tests;
   int fails;
   int data_err;
   int xfer_cnt;
   int resp_cnt;
   logic [11:0] exp_q[$];
   logic [23:0] ops  [4];
   logic [11:0] exps [4];
   logic [23:0] rnd;
   logic [11:0] got_exp;

   reduce_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .idle       (idle),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0; data_err = 0; xfer_cnt = 0; resp_cnt = 0;
      rst = 1'b1; req_valid = '0; req_data = '0;
      step();
      do_reset();
      settle();
      check("reset_resp_valid", 32'(resp_valid), 0);
      check("reset_resp_id", 32'(resp_id), 0);
      check("reset_op_count", 32'(op_count), 0);
      check("reset_idle", 32'(idle), 1);
      check("reset_ready", 32'(req_ready), 0);

      // single request on requester 0: 16652 = 3329*5 + 7
      req_valid = 4'b0001;
      req_data[0 +: 24] = 24'd16652;
      settle();
      check("single_ready", 32'(req_ready), 32'b0001);
      step();
      req_valid = '0;
      settle();
      check("single_idle_busy", 32'(idle), 0);
      check("single_no_early_resp", 32'(resp_valid), 0);
      step();
      settle();
      check("single_resp_valid", 32'(resp_valid), 1);
      check("single_resp_id", 32'(resp_id), 0);
      check("single_resp_data", 32'(resp_data), 7);
      check("single_op_count", 32'(op_count), 1);
      step();
      settle();
      check("single_resp_fall", 32'(resp_valid), 0);
      check("single_idle_back", 32'(idle), 1);

      // boundary operands on requester 2
      ops[0] = 24'd0;    exps[0] = 12'd0;
      ops[1] = 24'd3329; exps[1] = 12'd0;
      ops[2] = 24'd3328; exps[2] = 12'd3328;
      ops[3] = 24'd11075584; exps[3] = 12'd1;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) begin
            req_valid = 4'b0100;
            req_data[2*24 +: 24] = ops[i];
         end else begin
            req_valid = '0;
         end
         settle();
         if (i < 4) check($sformatf("bound_ready_%0d", i), 32'(req_ready), 32'b0100);
         if (i >= 2) begin
            check($sformatf("bound_valid_%0d", i-2), 32'(resp_valid), 1);
            check($sformatf("bound_id_%0d", i-2), 32'(resp_id), 2);
            check($sformatf("bound_data_%0d", i-2), 32'(resp_data), 32'(exps[i-2]));
         end
         step();
      end
      settle();
      check("bound_resp_done", 32'(resp_valid), 0);
      check("bound_op_count", 32'(op_count), 5);

      // fairness from reset: all four valid for 8 cycles
      do_reset();
      for (int j = 0; j < NREQ; j++) req_data[j*24 +: 24] = 24'(100*j + 5);
      for (int i = 0; i < 10; i++) begin
         req_valid = (i < 8) ? 4'b1111 : 4'b0000;
         settle();
         if (i < 8) check($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
         if (i >= 2) begin
            check($sformatf("rr_valid_%0d", i), 32'(resp_valid), 1);
            check($sformatf("rr_id_%0d", i), 32'(resp_id), 32'((i-2) % 4));
            check($sformatf("rr_data_%0d", i), 32'(resp_data), 32'(100*((i-2) % 4) + 5));
         end
         step();
      end
      settle();
      check("rr_op_count", 32'(op_count), 8);
      check("rr_ptr", 32'(dut.ptr), 0);

      // pointer skip: grant 0 so ptr=1, then only 0 and 3 valid
      req_valid = 4'b0001;
      settle();
      check("skip_first_ready", 32'(req_ready), 32'b0001);
      step();
      settle();
      check("skip_ptr_1", 32'(dut.ptr), 1);
      req_valid = 4'b1001;
      settle();
      check("skip_ready_3", 32'(req_ready), 32'b1000);
      step();
      settle();
      check("skip_ptr_0", 32'(dut.ptr), 0);
      check("skip_ready_0", 32'(req_ready), 32'b0001);
      step();
      settle();
      check("skip_ptr_back_1", 32'(dut.ptr), 1);
      req_valid = '0;
      step();
      step();
      step();

      // reset mid-flight: grant requester 1, reset the next cycle
      req_valid = 4'b0010;
      req_data[1*24 +: 24] = 24'd1234;
      settle();
      check("midrst_ready", 32'(req_ready), 32'b0010);
      step();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      settle();
      check("midrst_no_resp_t2", 32'(resp_valid), 0);
      check("midrst_op_count", 32'(op_count), 0);
      check("midrst_ptr", 32'(dut.ptr), 0);
      step();
      settle();
      check("midrst_no_resp_t3", 32'(resp_valid), 0);

      // counter wrap with random in-range operands and a result scoreboard
      do_reset();
      for (int n = 0; n < 65539; n++) begin
         if (n < 65537) begin
            rnd = 24'($urandom_range(0, 11075584));
            req_valid = 4'b0001;
            req_data[0 +: 24] = rnd;
         end else begin
            req_valid = '0;
         end
         settle();
         if (n == 65535) check("wrap_ffff", 32'(op_count), 32'hFFFF);
         if (n == 65536) check("wrap_0000", 32'(op_count), 32'h0000);
         if (n == 65537) check("wrap_0001", 32'(op_count), 32'h0001);
         if (req_valid[0] && req_ready[0]) begin
            xfer_cnt++;
            exp_q.push_back(12'(rnd % 24'd3329));
         end
         if (resp_valid) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
               data_err++;
            end else begin
               got_exp = exp_q.pop_front();
               if (resp_data !== got_exp || resp_id !== 2'd0) data_err++;
            end
         end
         step();
      end
      settle();
      check("wrap_xfer_count", 32'(xfer_cnt), 65537);
      check("wrap_resp_count", 32'(resp_cnt), 32'(xfer_cnt));
      check("wrap_data_errors", 32'(data_err), 0);
      check("wrap_idle_end", 32'(idle), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
